execute_stage_mc: RTL and testbench

EXECUTE_STAGE_MC -- requirements
Module: execute_stage_mc

---
 rtl/execute_stage_mc_pkg.sv | 50 +++++
 rtl/execute_stage_mc_iter_mul.sv | 98 +++++++++
 rtl/execute_stage_mc.sv | 167 ++++++++++++++++
 tb/tb_execute_stage_mc.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_mc_pkg.sv
// Shared types and encodings for the execute stage and its multiplier.
package ex_pkg;

  // ALU operation encodings carried in ctrl.alu_ctrl
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_e;

  // Forwarding mux select encodings (00 and 11 both pick the register operand)
  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] FWD_REG_ALT = 2'b11;

  // Iterative multiplier control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  // Control bundle travelling with the instruction from EX to M
  typedef struct packed {
    logic     reg_write;
    logic     mem_write;
    logic     result_src;
    logic     branch;
    logic     br_ne;
    logic     alu_src;
    alu_op_e  alu_ctrl;
    logic [1:0] rgb;
  } ex_ctrl_t;

  // Strip architectural side effects from a control word (used for bubbles)
  function automatic ex_ctrl_t kill_ctrl(input ex_ctrl_t c);
    ex_ctrl_t k;
    k           = c;
    k.reg_write = 1'b0;
    k.mem_write = 1'b0;
    return k;
  endfunction

endpackage

// File: rtl/execute_stage_mc_iter_mul.sv
// Shift-add multiplier: one partial product per cycle, low DATA_W bits kept.
module iter_mul
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  // Next-state logic: accept, step through DATA_W bits, present result for one cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = {DATA_W{1'b0}};
          cnt_d    = {CNT_W{1'b0}};
          state_d  = ST_MUL;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (abort) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end else begin
            acc_d = acc_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_MUL;
          end
        end
      end
      ST_DONE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      mcand_q  <= {DATA_W{1'b0}};
      mplier_q <= {DATA_W{1'b0}};
      acc_q    <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // Busy covers the accept cycle so upstream stalls from the first cycle on
  assign busy    = (state_q == ST_MUL) | ((state_q == ST_IDLE) & start);
  assign done    = (state_q == ST_DONE);
  assign product = acc_q;

endmodule

// File: rtl/execute_stage_mc.sv
// Execute stage: forwarding, ALU, branch resolve, iterative MUL and EX/M register.
module execute_stage_mc
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned RD_W   = 5,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_e,
  input  ex_ctrl_t          ctrl_e,
  input  logic [DATA_W-1:0] rd1_e,
  input  logic [DATA_W-1:0] rd2_e,
  input  logic [DATA_W-1:0] rd4_e,
  input  logic [DATA_W-1:0] imm_e,
  input  logic [RD_W-1:0]   rd_e,
  input  logic [DATA_W-1:0] pc_e,
  input  logic [DATA_W-1:0] pc_plus4_e,
  input  logic [DATA_W-1:0] result_w,
  input  logic [5:0]        fwd_e,
  input  logic              flush_e,
  output logic              pc_src_e,
  output logic [DATA_W-1:0] pc_target_e,
  output logic              busy_e,
  output logic              valid_m,
  output ex_ctrl_t          ctrl_m,
  output logic [RD_W-1:0]   rd_m,
  output logic [DATA_W-1:0] pc_plus4_m,
  output logic [DATA_W-1:0] write_data_m,
  output logic [DATA_W-1:0] alu_result_m
);

  logic [DATA_W-1:0] src_a_s, fwd_b_s, src_b_s, store_s, alu_res_s, mul_prod_s;
  logic              is_mul_s, mul_start_s, mul_busy_s, mul_done_s, zero_s, cond_s;
  logic              capture_s;

  logic              valid_q, valid_d;
  ex_ctrl_t          ctrl_q, ctrl_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;

  // Pick the operand source: writeback, M-stage result, or the register file
  function automatic logic [DATA_W-1:0] fwd_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] reg_v,
    input logic [DATA_W-1:0] wb_v,
    input logic [DATA_W-1:0] mem_v
  );
    logic [DATA_W-1:0] r;
    case (sel)
      FWD_WB:      r = wb_v;
      FWD_MEM:     r = mem_v;
      FWD_REG:     r = reg_v;
      FWD_REG_ALT: r = reg_v;
      default:     r = reg_v;
    endcase
    return r;
  endfunction

  // Operand forwarding and B-source selection
  always_comb begin
    src_a_s = fwd_mux(fwd_e[5:4], rd1_e, result_w, alu_q);
    fwd_b_s = fwd_mux(fwd_e[3:2], rd2_e, result_w, alu_q);
    store_s = fwd_mux(fwd_e[1:0], rd4_e, result_w, alu_q);
    if (ctrl_e.alu_src) begin
      src_b_s = imm_e;
    end else begin
      src_b_s = fwd_b_s;
    end
  end

  // Single-cycle ALU; MUL yields zero here, its result comes from iter_mul
  always_comb begin
    alu_res_s = {DATA_W{1'b0}};
    case (ctrl_e.alu_ctrl)
      ALU_ADD: alu_res_s = src_a_s + src_b_s;
      ALU_SUB: alu_res_s = src_a_s - src_b_s;
      ALU_AND: alu_res_s = src_a_s & src_b_s;
      ALU_OR:  alu_res_s = src_a_s | src_b_s;
      ALU_XOR: alu_res_s = src_a_s ^ src_b_s;
      ALU_SLL: alu_res_s = src_a_s << src_b_s[3:0];
      ALU_SRL: alu_res_s = src_a_s >> src_b_s[3:0];
      ALU_MUL: alu_res_s = {DATA_W{1'b0}};
      default: alu_res_s = {DATA_W{1'b0}};
    endcase
  end

  assign is_mul_s    = MUL_EN && (ctrl_e.alu_ctrl == ALU_MUL);
  assign mul_start_s = valid_e & ~flush_e & is_mul_s;
  assign zero_s      = (alu_res_s == {DATA_W{1'b0}});
  assign cond_s      = ctrl_e.br_ne ? ~zero_s : zero_s;

  // Branch resolves only for single-cycle ops; a MUL never redirects the PC
  assign pc_src_e    = valid_e & ~flush_e & ctrl_e.branch & ~is_mul_s & cond_s;
  assign pc_target_e = pc_e + imm_e;

  iter_mul #(
    .DATA_W (DATA_W)
  ) u_iter_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_s),
    .abort   (flush_e),
    .a       (src_a_s),
    .b       (src_b_s),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  assign busy_e    = mul_busy_s;
  assign capture_s = valid_e & ~flush_e & ~busy_e;

  // EX/M next value: real instruction when accepted, otherwise a cleared bubble
  always_comb begin
    valid_d = 1'b0;
    ctrl_d  = kill_ctrl('0);
    rd_d    = {RD_W{1'b0}};
    pc4_d   = {DATA_W{1'b0}};
    wdata_d = {DATA_W{1'b0}};
    alu_d   = {DATA_W{1'b0}};
    if (capture_s) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_e;
      rd_d    = rd_e;
      pc4_d   = pc_plus4_e;
      wdata_d = store_s;
      if (mul_done_s) begin
        alu_d = mul_prod_s;
      end else begin
        alu_d = alu_res_s;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // EX/M pipeline register with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd_q    <= {RD_W{1'b0}};
      pc4_q   <= {DATA_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      alu_q   <= {DATA_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      pc4_q   <= pc4_d;
      wdata_q <= wdata_d;
      alu_q   <= alu_d;
    end
  end

  assign valid_m      = valid_q;
  assign ctrl_m       = ctrl_q;
  assign rd_m         = rd_q;
  assign pc_plus4_m   = pc4_q;
  assign write_data_m = wdata_q;
  assign alu_result_m = alu_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Randomized self-checking bench for execute_stage_mc with a transaction-level model.
module tb_execute_stage_mc;
  import ex_pkg::*;

  localparam int DW = 18;
  localparam int RW = 5;
  localparam longint unsigned MOD = 64'd1 << DW;

  logic          clk, rst, valid_e, flush_e;
  ex_ctrl_t      ctrl_e, ctrl_m;
  logic [DW-1:0] rd1_e, rd2_e, rd4_e, imm_e, pc_e, pc_plus4_e, result_w;
  logic [RW-1:0] rd_e, rd_m;
  logic [5:0]    fwd_e;
  logic          pc_src_e, busy_e, valid_m;
  logic [DW-1:0] pc_target_e, pc_plus4_m, write_data_m, alu_result_m;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what the M stage should currently hold
  bit            m_prev_valid = 1'b0;
  logic [DW-1:0] m_prev_alu = '0;

  execute_stage_mc #(.DATA_W(DW), .RD_W(RW), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .ctrl_e(ctrl_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .rd4_e(rd4_e), .imm_e(imm_e), .rd_e(rd_e),
    .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .result_w(result_w), .fwd_e(fwd_e),
    .flush_e(flush_e), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .busy_e(busy_e), .valid_m(valid_m), .ctrl_m(ctrl_m), .rd_m(rd_m),
    .pc_plus4_m(pc_plus4_m), .write_data_m(write_data_m), .alu_result_m(alu_result_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_alu(input int op, input longint unsigned a,
                                            input longint unsigned b);
    longint unsigned r;
    case (op)
      0: r = (a + b) % MOD;
      1: r = (a + MOD - b) % MOD;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a * (64'd1 << (b % 16))) % MOD;
      6: r = a / (64'd1 << (b % 16));
      default: r = (a * b) % MOD;
    endcase
    return DW'(r);
  endfunction

  function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] r);
    if (sel == 2'd1) return result_w;
    if (sel == 2'd2) return m_prev_alu;
    return r;
  endfunction

  task automatic drive(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] imm,
                       input logic [5:0] fwd, input bit alu_src, input bit branch,
                       input bit br_ne, input bit valid, input bit flush,
                       input logic [DW-1:0] pc, input logic [DW-1:0] wb);
    @(negedge clk);
    ctrl_e.reg_write  = 1'($urandom);
    ctrl_e.mem_write  = 1'($urandom);
    ctrl_e.result_src = 1'($urandom);
    ctrl_e.rgb        = 2'($urandom);
    ctrl_e.branch     = branch;
    ctrl_e.br_ne      = br_ne;
    ctrl_e.alu_src    = alu_src;
    ctrl_e.alu_ctrl   = alu_op_e'(3'(op));
    rd1_e = a; rd2_e = b; rd4_e = c; imm_e = imm;
    fwd_e = fwd; valid_e = valid; flush_e = flush;
    pc_e = pc; pc_plus4_e = DW'((longint'(pc) + 4) % MOD);
    result_w = wb;
    rd_e = RW'($urandom);
  endtask

  task automatic do_single();
    logic [DW-1:0] a, b, c, res, tgt;
    bit taken, cap;
    a   = pick(fwd_e[5:4], rd1_e);
    b   = ctrl_e.alu_src ? imm_e : pick(fwd_e[3:2], rd2_e);
    c   = pick(fwd_e[1:0], rd4_e);
    res = ref_alu(int'(ctrl_e.alu_ctrl), a, b);
    taken = valid_e && !flush_e && ctrl_e.branch && (ctrl_e.alu_ctrl != ALU_MUL) &&
            (ctrl_e.br_ne ? (res != 0) : (res == 0));
    tgt = DW'((longint'(pc_e) + longint'(imm_e)) % MOD);
    #1;
    check_eq("pc_target", pc_target_e, tgt);
    check_eq("pc_src", pc_src_e, taken);
    check_eq("busy_single", busy_e, 0);
    @(posedge clk); #1;
    cap = valid_e && !flush_e;
    check_eq("valid_m", valid_m, cap);
    check_eq("reg_write_m", ctrl_m.reg_write, cap ? ctrl_e.reg_write : 1'b0);
    check_eq("mem_write_m", ctrl_m.mem_write, cap ? ctrl_e.mem_write : 1'b0);
    if (cap) begin
      check_eq("alu_result_m", alu_result_m, res);
      check_eq("ctrl_m", ctrl_m, ctrl_e);
      check_eq("rd_m", rd_m, rd_e);
      check_eq("write_data_m", write_data_m, c);
      check_eq("pc_plus4_m", pc_plus4_m, pc_plus4_e);
    end
    m_prev_valid = cap;
    if (cap) m_prev_alu = res;
  endtask

  task automatic do_mul(input int flush_at, input bit flush_done);
    logic [DW-1:0] a, b, c, prod;
    int busy_cnt;
    bit flushed;
    a    = pick(fwd_e[5:4], rd1_e);
    b    = ctrl_e.alu_src ? imm_e : pick(fwd_e[3:2], rd2_e);
    c    = pick(fwd_e[1:0], rd4_e);
    prod = ref_alu(7, a, b);
    #1;
    check_eq("mul_pc_src", pc_src_e, 0);
    busy_cnt = 0;
    flushed  = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (!busy_e) break;
      busy_cnt++;
      if (cyc == flush_at) flush_e = 1'b1;
      @(posedge clk); #1;
      check_eq("mul_bubble_valid", valid_m, 0);
      if (flush_e) begin
        flushed = 1'b1;
        flush_e = 1'b0;
        valid_e = 1'b0;
        #1;
        check_eq("mul_flush_busy", busy_e, 0);
        break;
      end
    end
    if (flushed) begin
      m_prev_valid = 1'b0;
    end else begin
      check_eq("mul_busy_len", busy_cnt, DW + 1);
      check_eq("mul_done_pc_src", pc_src_e, 0);
      if (flush_done) begin
        flush_e = 1'b1;
        @(posedge clk); #1;
        check_eq("done_flush_valid", valid_m, 0);
        check_eq("done_flush_regw", ctrl_m.reg_write, 0);
        flush_e = 1'b0;
        valid_e = 1'b0;
        #1;
        check_eq("done_flush_busy", busy_e, 0);
        m_prev_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
        check_eq("mul_valid_m", valid_m, 1);
        check_eq("mul_product", alu_result_m, prod);
        check_eq("mul_rd_m", rd_m, rd_e);
        check_eq("mul_write_data", write_data_m, c);
        check_eq("mul_pc_plus4", pc_plus4_m, pc_plus4_e);
        m_prev_valid = 1'b1;
        m_prev_alu   = prod;
      end
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    case ($urandom % 4)
      0: return DW'($urandom % 16);
      1: return DW'($urandom);
      2: return DW'(MOD - 1 - ($urandom % 4));
      default: return DW'($urandom % 1024);
    endcase
  endfunction

  initial begin
    rst = 1'b0; valid_e = 1'b0; flush_e = 1'b0; ctrl_e = '0;
    rd1_e = '0; rd2_e = '0; rd4_e = '0; imm_e = '0; pc_e = '0; pc_plus4_e = '0;
    result_w = '0; fwd_e = '0; rd_e = '0;
    #1;
    check_eq("rst_valid_m", valid_m, 0);
    check_eq("rst_alu_m", alu_result_m, 0);
    check_eq("rst_ctrl_m", ctrl_m, 0);
    check_eq("rst_busy", busy_e, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_valid_m", valid_m, 0);

    // ADD 5+7
    drive(0, 18'd5, 18'd7, 18'd0, 18'd0, 6'b000000, 0, 0, 0, 1, 0, 18'h10, 18'd0);
    do_single();
    check_eq("add_5_7", alu_result_m, 12);

    // SUB 3-3 branch on equal
    drive(1, 18'd3, 18'd3, 18'd0, 18'h20, 6'b000000, 0, 1, 0, 1, 0, 18'h100, 18'd0);
    #1;
    check_eq("beq_taken", pc_src_e, 1);
    check_eq("beq_target", pc_target_e, 18'h120);
    do_single();

    // Forwarding wrap and writeback forward
    drive(0, 18'h3FFFF, 18'd0, 18'd0, 18'd0, 6'b000000, 0, 0, 0, 1, 0, 18'h0, 18'd0);
    do_single();
    drive(0, 18'd0, 18'd1, 18'd0, 18'd0, 6'b100000, 0, 0, 0, 1, 0, 18'h4, 18'd0);
    do_single();
    check_eq("fwd_mem_wrap", alu_result_m, 0);
    drive(0, 18'd0, 18'd1, 18'd0, 18'd0, 6'b010000, 0, 0, 0, 1, 0, 18'h8, 18'd9);
    do_single();
    check_eq("fwd_wb_add", alu_result_m, 10);

    // MUL 300x200
    drive(7, 18'd300, 18'd200, 18'd5, 18'd0, 6'b000000, 0, 0, 0, 1, 0, 18'hC, 18'd0);
    do_mul(0, 0);
    check_eq("mul_300_200", alu_result_m, 60000);

    // MUL flushed in its fifth busy cycle, then one flushed in DONE
    drive(7, 18'd77, 18'd91, 18'd0, 18'd0, 6'b000000, 0, 0, 0, 1, 0, 18'h10, 18'd0);
    do_mul(5, 0);
    drive(7, 18'd13, 18'd11, 18'd0, 18'd0, 6'b000000, 0, 0, 0, 1, 0, 18'h14, 18'd0);
    do_mul(0, 1);

    // Asynchronous reset clears a live M stage before the next edge
    drive(0, 18'd40, 18'd2, 18'd0, 18'd0, 6'b000000, 0, 0, 0, 1, 0, 18'h18, 18'd0);
    do_single();
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_valid", valid_m, 0);
    check_eq("async_rst_alu", alu_result_m, 0);
    @(negedge clk); rst = 1'b1;
    m_prev_valid = 1'b0;

    // Reset mid-MUL abandons the operation
    drive(7, 18'd1000, 18'd3, 18'd0, 18'd0, 6'b000000, 0, 0, 0, 1, 0, 18'h1C, 18'd0);
    repeat (7) @(posedge clk);
    #2;
    check_eq("mid_mul_busy", busy_e, 1);
    rst = 1'b0; valid_e = 1'b0;
    #1;
    check_eq("mid_mul_rst_busy", busy_e, 0);
    check_eq("mid_mul_rst_valid", valid_m, 0);
    check_eq("mid_mul_rst_alu", alu_result_m, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_mul_after_rst", valid_m, 0);
    m_prev_valid = 1'b0;

    // Randomized instruction stream
    for (int i = 0; i < 120; i++) begin
      int op;
      logic [DW-1:0] a, b;
      logic [1:0] fa, fb, fc;
      bit v, f;
      op = int'($urandom % 8);
      a  = rand_data();
      b  = ($urandom % 4 == 0) ? a : rand_data();
      fa = 2'($urandom); fb = 2'($urandom); fc = 2'($urandom);
      if (!m_prev_valid && fa == 2'd2) fa = 2'd0;
      if (!m_prev_valid && fb == 2'd2) fb = 2'd0;
      if ((!m_prev_valid || op == 7) && fc == 2'd2) fc = 2'd0;
      v = ($urandom % 10) != 0;
      f = ($urandom % 10) == 0;
      drive(op, a, b, rand_data(), rand_data(), {fa, fb, fc}, 1'($urandom % 4 == 0),
            1'($urandom), 1'($urandom), v, f, rand_data(), rand_data());
      if (op == 7 && v && !f) begin
        do_mul(($urandom % 6 == 0) ? int'(2 + $urandom % 18) : 0, 1'($urandom % 8 == 0));
      end else begin
        do_single();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
